alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-requester scheduler for the shared 16-bit ALU (ops ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB). Port 0 is the execute stage, whose ops write the architectural flag register. Port 1 is a secondary requester, e.g. an address or branch-target unit, whose ops never touch flags. The block arbitrates round-robin, registers the winning operands into the ALU, captures the result, and returns it with a one-cycle response pulse. It owns the Z/V/N flag register.

## Interface
Parameters:
- W, 16, datapath width (ALU is fixed 16; parameter exists for bench sizing only)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present; held with operands until accepted
- req0_op / req1_op  in  3  ALU opcode (000 ADD … 111 PADDSB)
- req0_a, req0_b / req1_a, req1_b  in  W  operands
- req0_ready / req1_ready  out  1  accept; handshake = valid & ready in same cycle
- alu_a, alu_b  out  W  registered operands to ALU
- alu_op  out  3  registered opcode to ALU
- alu_result  in  W  ALU combinational result
- alu_ovfl, alu_zero, alu_sign  in  1  ALU flag outputs
- rsp0_valid / rsp1_valid  out  1  one-cycle result pulse to owning requester
- rsp_result  out  W  registered result, shared by both ports
- flag_z, flag_v, flag_n  out  1  architectural flags

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: accept if any request. Otherwise stay.
  - Accept: latch operands, opcode and owner into the alu_* registers, then go to EXEC.
  - EXEC: the ALU evaluates. At the edge, capture alu_result into rsp_result and go to RESP.
  - RESP: the owner's rsp valid is high. The block may accept a new request in this same cycle. It goes to EXEC if it accepted, else IDLE.
- Accepting states are IDLE and RESP. readyN = accepting & grantN.
  - Grant is combinational from the valids and a priority bit.
  - readyN may depend combinationally on reqN_valid. Requesters must not make valid depend on ready.
- Round-robin:
  - The priority bit names the preferred port and resets to port 0.
  - If only one port is valid, that port wins.
  - If both are valid, the preferred port wins.
  - After any accept, the priority bit points to the other port.
- Flag update, port-0 ops only, written at the EXEC edge:
  - ADD, SUB: Z, V, N ← alu_zero, alu_ovfl, alu_sign.
  - XOR, SLL, SRA, ROR: Z only; V and N hold.
  - RED, PADDSB: no flags change.
- Port-1 ops never modify flags.
- alu_* registers hold their last values when the block is idle; no toggling without an accept.

## Timing
- Reset values:
  - alu_a = alu_b = 0, alu_op = 000.
  - rsp_result = 0.
  - rsp0_valid = rsp1_valid = 0.
  - flags all 0.
  - state IDLE, priority = port 0.
  - req*_ready is 0 unless the corresponding valid is high.
- Latency:
  - Accept at cycle T. alu_* valid in T+1. rsp_result and rspN_valid valid in T+2.
  - Flags are visible from T+2.
- Throughput: one op per 2 cycles sustained (accept in RESP overlaps).
- rspN_valid is exactly one cycle wide. rsp_result holds until the next capture.
- Both valid every accepting cycle: grants alternate 0,1,0,1…
- Reset mid-operation, at any state: all outputs return to reset values immediately (asynchronously). An in-flight op produces no response after release, and flags stay 0.
- Reset release: first accept possible in the first clock edge with rst_n high.

## Test plan
Bench instantiates this block with ALU_Top connected.
- Port 0, SUB a=0x0005 b=0x0005, accepted at T -> rsp0_valid only at T+2, rsp_result=0x0000; flag_z=1, flag_v=0, flag_n=0 from T+2.
- Following test 1: port 1, XOR a=0x7459 b=0x0000 -> rsp1_valid at T+2, rsp_result=0x7459; flags stay Z=1, V=0, N=0.
- Port 0, SLL a=0x0010 b=0x0004 after an ADD that set V=1 -> rsp_result=0x0100; Z=0, V stays 1.
- Both valid continuously from reset release, port0 ADD 1+1 and port1 ADD 2+2 -> accepts alternate port0, port1, port0… every 2 cycles; rsp0 result 0x0002, rsp1 result 0x0004; flags updated only on port-0 ops.
- Port 0 only, valid held for 3 ops -> accepts at T, T+2, T+4; req0_ready low in EXEC cycles.
- rst_n low during EXEC -> alu_*, rsp_result and flags read 0 immediately; no rsp*_valid after release until a new accept.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Two-requester round-robin scheduler in front of the shared 16-bit ALU.
//   Port 0 (execute stage) owns the architectural Z/V/N flags; port 1
//   (secondary unit) never touches them. A winning request is registered
//   into the ALU operand registers, the ALU result is captured one cycle
//   later, and the owner receives a one-cycle response pulse. A new request
//   may be accepted in the response cycle, giving one op per two cycles.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/op/a/b          request from port N, held until accepted
//   reqN_ready                 accept (handshake = valid & ready)
//   alu_a, alu_b, alu_op       registered operands/opcode to the ALU
//   alu_result, alu_ovfl,
//   alu_zero, alu_sign         combinational ALU outputs
//   rspN_valid                 one-cycle result pulse to port N
//   rsp_result                 captured result, shared by both ports
//   flag_z, flag_v, flag_n     architectural flags
module alu_share_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_ovfl,
  input  logic         alu_zero,
  input  logic         alu_sign,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_result,
  output logic         flag_z,
  output logic         flag_v,
  output logic         flag_n
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_ROR = 3'b110;

  state_t       state_q, state_d;
  logic         prio_q, prio_d;     // 1 = port 1 preferred on a tie
  logic         owner_q;            // port that owns the in-flight op
  logic [W-1:0] alu_a_q, alu_b_q, rsp_result_q;
  logic [2:0]   alu_op_q;
  logic         rsp0_q, rsp1_q;
  logic         flag_z_q, flag_v_q, flag_n_q;

  logic         grant0, grant1, accepting, accept;
  logic         upd_zvn, upd_z;

  // Grant is purely a function of the valids and the priority bit, so
  // ready can follow valid within the same cycle.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~prio_q);
    grant1     = req1_valid & (~req0_valid |  prio_q);
    accepting  = (state_q == IDLE) || (state_q == RESP);
    req0_ready = accepting & grant0;
    req1_ready = accepting & grant1;
    accept     = req0_ready | req1_ready;
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE:    state_d = accept ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      RESP:    state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
    // After any accept the other port becomes preferred.
    if (accept) prio_d = req0_ready;
  end

  // Flag write enables; only port-0 ops in EXEC may update flags.
  always_comb begin
    upd_zvn = 1'b0;
    upd_z   = 1'b0;
    if ((state_q == EXEC) && !owner_q) begin
      case (alu_op_q)
        OP_ADD, OP_SUB:                 upd_zvn = 1'b1;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd_z   = 1'b1;
        default:                        ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 3'b000;
      rsp_result_q <= '0;
      rsp0_q       <= 1'b0;
      rsp1_q       <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      // Operand registers only move on an accept, so the ALU inputs stay
      // quiet while idle.
      if (accept) begin
        owner_q  <= req1_ready;
        alu_a_q  <= req0_ready ? req0_a  : req1_a;
        alu_b_q  <= req0_ready ? req0_b  : req1_b;
        alu_op_q <= req0_ready ? req0_op : req1_op;
      end
      // Response pulses are set only by the EXEC edge, so they last
      // exactly the single RESP cycle.
      rsp0_q <= (state_q == EXEC) & ~owner_q;
      rsp1_q <= (state_q == EXEC) &  owner_q;
      if (state_q == EXEC) rsp_result_q <= alu_result;
      if (upd_zvn) begin
        flag_z_q <= alu_zero;
        flag_v_q <= alu_ovfl;
        flag_n_q <= alu_sign;
      end else if (upd_z) begin
        flag_z_q <= alu_zero;
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign flag_z     = flag_z_q;
  assign flag_v     = flag_v_q;
  assign flag_n     = flag_n_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with a small behavioural model of the shared ALU.
module tb_alu_share_ctrl;
  localparam int W = 16;

  logic         clk, rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op, alu_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] alu_a, alu_b, alu_result, rsp_result;
  logic         alu_ovfl, alu_zero, alu_sign;
  logic         rsp0_valid, rsp1_valid, flag_z, flag_v, flag_n;

  int checks = 0;
  int errors = 0;

  alu_share_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_ovfl(alu_ovfl), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  // Behavioural ALU: ADD SUB XOR RED SLL SRA ROR PADDSB
  logic [15:0] m_res;
  logic        m_ov;
  logic [31:0] m_dbl;
  logic [8:0]  m_lo, m_hi;
  always_comb begin
    m_res = '0;
    m_ov  = 1'b0;
    m_dbl = '0;
    m_lo  = '0;
    m_hi  = '0;
    case (alu_op)
      3'd0: begin
        m_res = alu_a + alu_b;
        m_ov  = (alu_a[15] == alu_b[15]) && (m_res[15] != alu_a[15]);
      end
      3'd1: begin
        m_res = alu_a - alu_b;
        m_ov  = (alu_a[15] != alu_b[15]) && (m_res[15] != alu_a[15]);
      end
      3'd2: m_res = alu_a ^ alu_b;
      3'd3: m_res = {15'd0, ^alu_a};
      3'd4: m_res = alu_a << alu_b[3:0];
      3'd5: m_res = $unsigned($signed(alu_a) >>> alu_b[3:0]);
      3'd6: begin
        m_dbl = {alu_a, alu_a} >> alu_b[3:0];
        m_res = m_dbl[15:0];
      end
      default: begin
        m_lo = {alu_a[7], alu_a[7:0]} + {alu_b[7], alu_b[7:0]};
        m_hi = {alu_a[15], alu_a[15:8]} + {alu_b[15], alu_b[15:8]};
        m_res[7:0]  = (m_lo[8] != m_lo[7]) ? (m_lo[8] ? 8'h80 : 8'h7F) : m_lo[7:0];
        m_res[15:8] = (m_hi[8] != m_hi[7]) ? (m_hi[8] ? 8'h80 : 8'h7F) : m_hi[7:0];
      end
    endcase
  end
  assign alu_result = m_res;
  assign alu_ovfl   = m_ov;
  assign alu_zero   = (m_res == 16'h0000);
  assign alu_sign   = m_res[15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic z, input logic v, input logic n);
    check_eq({tag, "_flags"}, 32'({flag_z, flag_v, flag_n}), 32'({z, v, n}));
  endtask

  // Issue one op on a port starting at a falling edge; returns at the falling
  // edge of the response cycle (T+2), where the block can accept again.
  task automatic run_op(input int port, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res,
                        input logic ez, input logic ev, input logic en);
    int n;
    logic rdy;
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    n = 0;
    rdy = (port == 0) ? req0_ready : req1_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      n++;
      rdy = (port == 0) ? req0_ready : req1_ready;
    end
    check_eq("accept_ready", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("exec_alu_a", 32'(alu_a), 32'(a));
    check_eq("exec_alu_b", 32'(alu_b), 32'(b));
    check_eq("exec_alu_op", 32'(alu_op), 32'(op));
    check_eq("exec_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    @(negedge clk);
    check_eq("rsp0_valid", 32'(rsp0_valid), 32'(port == 0));
    check_eq("rsp1_valid", 32'(rsp1_valid), 32'(port == 1));
    check_eq("rsp_result", 32'(rsp_result), 32'(exp_res));
    check_flags("rsp", ez, ev, en);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;

    // Reset state
    @(negedge clk); #1;
    check_eq("rst_alu", 32'({alu_a, alu_b}), 32'd0);
    check_eq("rst_op", 32'(alu_op), 32'd0);
    check_eq("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp_result}), 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check_eq("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Port 0 SUB 5-5: Z=1 V=0 N=0
    run_op(0, 3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0);
    // Port 1 XOR: result passes through, flags untouched
    run_op(1, 3'd2, 16'h7459, 16'h0000, 16'h7459, 1'b1, 1'b0, 1'b0);
    // Port 0 ADD overflow, then SLL (Z only), then RED (no flags)
    run_op(0, 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
    run_op(0, 3'd4, 16'h0010, 16'h0004, 16'h0100, 1'b0, 1'b1, 1'b1);
    run_op(0, 3'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Port 0 held valid for three ADD 1+1 ops: accepts every other cycle
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0001; req0_b = 16'h0001;
    #1;
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("held_ready0_%0d", i), 32'(req0_ready), 32'((i % 2 == 0) && (i <= 4)));
      if (i >= 1) check_eq($sformatf("held_rsp0_%0d", i), 32'(rsp0_valid), 32'(i % 2 == 0));
      if (i >= 2 && i % 2 == 0) check_eq($sformatf("held_res_%0d", i), 32'(rsp_result), 32'h0002);
      if (i == 4) begin
        @(posedge clk); #1;
        req0_valid = 1'b0;
      end
      @(negedge clk); #1;
    end
    check_flags("held", 1'b0, 1'b0, 1'b0);

    // Reset asserted while an op is in EXEC
    run_op(0, 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 16'h0005; req0_b = 16'h0003;
    #1;
    check_eq("mid_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_exec_a", 32'(alu_a), 32'h0005);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_alu", 32'({alu_a, alu_b}), 32'd0);
    check_eq("mid_rst_op", 32'(alu_op), 32'd0);
    check_eq("mid_rst_res", 32'(rsp_result), 32'd0);
    check_eq("mid_rst_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports valid from release: grants alternate 0,1,0,1
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0001; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 16'h0002; req1_b = 16'h0002;
    #1;
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("rr_ready0_%0d", i), 32'(req0_ready), 32'((i % 4 == 0) && (i < 8)));
      check_eq($sformatf("rr_ready1_%0d", i), 32'(req1_ready), 32'(i % 4 == 2));
      check_eq($sformatf("rr_rsp0_%0d", i), 32'(rsp0_valid), 32'(i % 4 == 2));
      check_eq($sformatf("rr_rsp1_%0d", i), 32'(rsp1_valid), 32'((i > 0) && (i % 4 == 0)));
      if (i >= 2 && i % 2 == 0)
        check_eq($sformatf("rr_res_%0d", i), 32'(rsp_result), (i % 4 == 2) ? 32'h0002 : 32'h0004);
      if (i == 1) check_flags("rr_after_rst", 1'b0, 1'b0, 1'b0);
      if (i == 7) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk); #1;
    end
    check_eq("rr_idle_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
